// File: rtl/dmem_ctrl_if.sv
// Core-side data-memory bus between the MEM stage and dmem_ctrl.
// The core is the master; the controller is the slave.
interface dmem_ctrl_if;
    logic [31:0] dad;
    logic [31:0] ddt_wr;
    logic [31:0] ddt_rd;
    logic        mreq;
    logic        write;
    logic [1:0]  size;
    logic        ackd_n;
    logic        fault;

    modport master (
        output dad, ddt_wr, mreq, write, size,
        input  ddt_rd, ackd_n, fault
    );

    modport slave (
        input  dad, ddt_wr, mreq, write, size,
        output ddt_rd, ackd_n, fault
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM behind the core MEM-stage bus,
// programmable wait states, byte/half lane steering, fault reporting.
module dmem_ctrl #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t      state, nxt;
    logic [3:0]  cnt;
    logic [31:0] a_q, d_q;
    logic        w_q;
    logic [1:0]  sz_q;

    logic [31:0] a_s;
    logic [1:0]  sz_s;
    logic        flt_s;
    logic [31:0] word_s, rd_s;
    logic [3:0]  be;
    logic [31:0] wd;

    logic [31:0] mem [2**AW];

    function automatic logic is_fault(logic [31:0] a, logic [1:0] sz);
        logic f;
        f = (a[31:AW+2] != BASE_ADDR[31:AW+2]);
        case (sz)
            2'b00:   f = f;
            2'b01:   f = f | a[0];
            2'b10:   f = f | (a[1:0] != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    // In IDLE the access is decoded straight off the bus (zero-wait path),
    // afterwards from the latched copy so mid-request changes are ignored.
    always_comb begin
        a_s    = (state == IDLE) ? bus.dad  : a_q;
        sz_s   = (state == IDLE) ? bus.size : sz_q;
        flt_s  = is_fault(a_s, sz_s);
        word_s = mem[a_s[AW+1:2]];
        rd_s   = 32'd0;
        case (sz_s)
            2'b00:   rd_s = 32'(word_s[{a_s[1:0], 3'b000} +: 8]);
            2'b01:   rd_s = 32'(word_s[{a_s[1], 4'b0000} +: 16]);
            2'b10:   rd_s = word_s;
            default: rd_s = 32'd0;
        endcase
    end

    // Store byte enables and lane-replicated write data from latched fields.
    always_comb begin
        be = 4'b0000;
        wd = d_q;
        case (sz_q)
            2'b00: begin
                be = 4'b0001 << a_q[1:0];
                wd = {4{d_q[7:0]}};
            end
            2'b01: begin
                be = a_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{d_q[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Next-state logic: capture, wait-state countdown, abort, single ACK.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (bus.mreq) nxt = (WAIT_STATES == 0) ? ACK : BUSY;
            BUSY: begin
                if (!bus.mreq)     nxt = IDLE;
                else if (cnt == 0) nxt = ACK;
            end
            ACK:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Request latch, counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            a_q        <= 32'd0;
            d_q        <= 32'd0;
            w_q        <= 1'b0;
            sz_q       <= 2'b00;
            bus.ackd_n <= 1'b1;
            bus.fault  <= 1'b0;
            bus.ddt_rd <= 32'd0;
        end else begin
            bus.ackd_n <= (nxt != ACK);
            bus.fault  <= (nxt == ACK) && flt_s;
            if (state == IDLE && bus.mreq) begin
                a_q  <= bus.dad;
                d_q  <= bus.ddt_wr;
                w_q  <= bus.write;
                sz_q <= bus.size;
                cnt  <= CNT_INIT;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (nxt == ACK && state != ACK)
                bus.ddt_rd <= flt_s ? 32'd0 : rd_s;
        end
    end

    // Store commit on the edge that ends ACK; reset discards it.
    always_ff @(posedge clk) begin
        if (!rst && state == ACK && w_q && !flt_s) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[a_q[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table on a 2-wait-state
// instance, hand sequences for abort, reset-in-ACK and zero-wait issue.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_ctrl_if b2 ();
    dmem_ctrl_if b0 ();

    dmem_ctrl #(.WAIT_STATES(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    dmem_ctrl #(.WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        flt;
        logic        chk;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        flt;
        logic        chk;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq0[$];
    vec_t tv[21];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic access(vec_t v, string nm);
        exp_t e;
        int   cyc;
        bit   got;
        e.rd  = v.rd;
        e.flt = v.flt;
        e.chk = v.chk;
        sbq.push_back(e);
        b2.dad    = v.a;
        b2.ddt_wr = v.d;
        b2.write  = v.wr;
        b2.size   = v.sz;
        b2.mreq   = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (b2.ackd_n == 1'b0) got = 1;
        end
        b2.mreq = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got no ack want ack", nm);
            void'(sbq.pop_back());
            return;
        end
        chk({nm, " latency"}, 32'(cyc), 32'd3);
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got ack want none", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, " fault"}, 32'(b2.fault), 32'(e.flt));
            if (e.chk) chk({nm, " rd"}, b2.ddt_rd, e.rd);
        end
        @(posedge clk);
        #1;
        chk({nm, " ack one cycle"}, 32'(b2.ackd_n), 32'd1);
    endtask

    task automatic b2b0(logic wr, logic [31:0] a0, logic [31:0] d0,
                        logic [31:0] a1, logic [31:0] d1, string nm);
        exp_t e;
        logic [4:0] mask;
        e.flt = 1'b0;
        e.chk = !wr;
        e.rd  = d0;
        sbq0.push_back(e);
        e.rd  = d1;
        sbq0.push_back(e);
        b0.dad    = a0;
        b0.ddt_wr = d0;
        b0.write  = wr;
        b0.size   = 2'b10;
        b0.mreq   = 1'b1;
        mask = 5'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (b0.ackd_n == 1'b0) begin
                mask[c] = 1'b1;
                if (sbq0.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: got extra ack want none", nm);
                end else begin
                    e = sbq0.pop_front();
                    chk({nm, " fault"}, 32'(b0.fault), 32'(e.flt));
                    if (e.chk) chk({nm, " rd"}, b0.ddt_rd, e.rd);
                end
            end
            if (c == 1) begin
                b0.dad    = a1;
                b0.ddt_wr = d1;
            end
            if (c == 3) b0.mreq = 1'b0;
        end
        chk({nm, " ack cycles"}, 32'(mask), 32'h0A);
        sbq0.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        bit   got;
        vec_t v;

        tv[0]  = '{1'b1, 2'b10, 32'h0001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 2'b10, 32'h0001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1};
        tv[2]  = '{1'b1, 2'b10, 32'h0001_0010, 32'h1122_3344, 32'h0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 2'b00, 32'h0001_0012, 32'h0000_00AA, 32'h0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 2'b10, 32'h0001_0010, 32'h0, 32'h11AA_3344, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 2'b01, 32'h0001_0012, 32'h0, 32'h0000_11AA, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 2'b00, 32'h0001_0011, 32'h0, 32'h0000_0033, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 2'b01, 32'h0001_0010, 32'h0000_5566, 32'h0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 2'b10, 32'h0001_0010, 32'h0, 32'h11AA_5566, 1'b0, 1'b1};
        tv[9]  = '{1'b0, 2'b00, 32'h0001_0013, 32'h0, 32'h0000_0011, 1'b0, 1'b1};
        tv[10] = '{1'b1, 2'b10, 32'h0001_0000, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0};
        tv[11] = '{1'b0, 2'b01, 32'h0001_0001, 32'h0, 32'h0, 1'b1, 1'b1};
        tv[12] = '{1'b1, 2'b10, 32'h0000_0000, 32'h1234_5678, 32'h0, 1'b1, 1'b1};
        tv[13] = '{1'b0, 2'b10, 32'h0001_0000, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1};
        tv[14] = '{1'b0, 2'b11, 32'h0001_0008, 32'h0, 32'h0, 1'b1, 1'b1};
        tv[15] = '{1'b0, 2'b10, 32'h0001_000A, 32'h0, 32'h0, 1'b1, 1'b1};
        tv[16] = '{1'b0, 2'b10, 32'h0001_1000, 32'h0, 32'h0, 1'b1, 1'b1};
        tv[17] = '{1'b1, 2'b10, 32'h0001_0FFC, 32'h0F0F_0F0F, 32'h0, 1'b0, 1'b0};
        tv[18] = '{1'b0, 2'b10, 32'h0001_0FFC, 32'h0, 32'h0F0F_0F0F, 1'b0, 1'b1};
        tv[19] = '{1'b1, 2'b00, 32'h0001_0FFF, 32'h0000_00F0, 32'h0, 1'b0, 1'b0};
        tv[20] = '{1'b0, 2'b10, 32'h0001_0FFC, 32'h0, 32'hF00F_0F0F, 1'b0, 1'b1};

        rst = 1'b1;
        b2.mreq = 1'b0; b2.write = 1'b0; b2.size = 2'b10;
        b2.dad = 32'h0; b2.ddt_wr = 32'h0;
        b0.mreq = 1'b0; b0.write = 1'b0; b0.size = 2'b10;
        b0.dad = 32'h0; b0.ddt_wr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset ackd_n", 32'(b2.ackd_n), 32'd1);
        chk("reset ddt_rd", b2.ddt_rd, 32'd0);
        chk("reset fault", 32'(b2.fault), 32'd0);
        chk("reset ackd_n ws0", 32'(b0.ackd_n), 32'd1);

        for (int i = 0; i < 21; i++)
            access(tv[i], $sformatf("vec%0d", i));

        b2.dad = 32'h0001_0008; b2.ddt_wr = 32'h0BAD_F00D;
        b2.write = 1'b1; b2.size = 2'b10; b2.mreq = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy ackd_n", 32'(b2.ackd_n), 32'd1);
        b2.mreq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort no ack", 32'(b2.ackd_n), 32'd1);
        end
        v = '{1'b0, 2'b10, 32'h0001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1};
        access(v, "after abort");

        b2.dad = 32'h0001_0008; b2.ddt_wr = 32'h5555_5555;
        b2.write = 1'b1; b2.size = 2'b10; b2.mreq = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (b2.ackd_n == 1'b0) got = 1;
        end
        chk("rst-in-ack reached ack", 32'(got), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        b2.mreq = 1'b0;
        chk("rst-in-ack ackd_n", 32'(b2.ackd_n), 32'd1);
        chk("rst-in-ack ddt_rd", b2.ddt_rd, 32'd0);
        chk("rst-in-ack fault", 32'(b2.fault), 32'd0);
        access(v, "after rst-in-ack");

        b2b0(1'b1, 32'h0001_0000, 32'hA1A2_A3A4,
             32'h0001_0004, 32'hB1B2_B3B4, "ws0 stores");
        @(posedge clk);
        #1;
        b2b0(1'b0, 32'h0001_0000, 32'hA1A2_A3A4,
             32'h0001_0004, 32'hB1B2_B3B4, "ws0 loads");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
